// File: rtl/usb_pkg.sv
// ============================================================================
// Module      : usb_pkg
// Description : Line-state and bus-state encodings shared by the bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'b00,
    ST_BUS_RESET = 2'b01,
    ST_SUSPEND   = 2'b10
  } bus_state_t;

endpackage

`default_nettype wire

// File: rtl/usb_bus_state_if.sv
// ============================================================================
// Module      : usb_bus_state_if
// Description : Pin inputs and bus-condition outputs of the bus-state monitor.
//               se1_err is present only when USB_SE1_DETECT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface usb_bus_state_if;
  import usb_pkg::*;

  logic        dp;
  logic        dm;
  line_state_t line_state;
  logic        bus_reset;
  logic        suspend;
  logic        resume;
`ifdef USB_SE1_DETECT_EN
  logic        se1_err;

  modport master (output dp, dm, input line_state, bus_reset, suspend, resume, se1_err);
  modport slave  (input dp, dm, output line_state, bus_reset, suspend, resume, se1_err);
`else
  modport master (output dp, dm, input line_state, bus_reset, suspend, resume);
  modport slave  (input dp, dm, output line_state, bus_reset, suspend, resume);
`endif

endinterface

`default_nettype wire

// File: rtl/usb_line_sync.sv
// ============================================================================
// Module      : usb_line_sync
// Description : Two-flop synchronizer for {dp,dm}, asynchronously reset to J.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_line_sync
  import usb_pkg::*;
(
  input  wire         clk,
  input  wire         reset_n,
  input  wire         dp,
  input  wire         dm,
  output line_state_t stage1,
  output line_state_t line_state
);

  line_state_t stage1_q, stage1_d;
  line_state_t stage2_q, stage2_d;

  always_comb begin
    stage1_d = line_state_t'({dp, dm});
    stage2_d = stage1_q;
  end

  // Reset to J so that leaving reset never looks like the start of an SE0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage1_q <= LS_J;
      stage2_q <= LS_J;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign stage1     = stage1_q;
  assign line_state = stage2_q;

endmodule

`default_nettype wire

// File: rtl/usb_bus_state.sv
// ============================================================================
// Module      : usb_bus_state
// Description : Full-speed USB device-side bus-state monitor: bus reset,
//               suspend and resume detection. Optional SE1 error pulse is
//               enabled with the USB_SE1_DETECT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_bus_state
  import usb_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 60,
  parameter int unsigned SUSPEND_CYCLES = 72000,
  parameter int unsigned RESUME_CYCLES  = 480
) (
  input wire             clk,
  input wire             reset_n,
  usb_bus_state_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SUSPEND_CYCLES + 1);

  localparam logic [CNT_W-1:0] c_reset_last   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_suspend_last = CNT_W'(SUSPEND_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_resume_last  = CNT_W'(RESUME_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max      = CNT_W'(SUSPEND_CYCLES);

  line_state_t w_stage1;
  line_state_t w_line_state;

  usb_line_sync u_line_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .dp         (bus.dp),
    .dm         (bus.dm),
    .stage1     (w_stage1),
    .line_state (w_line_state)
  );

  line_state_t      prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_run;
  bus_state_t       state_q, state_d;
  logic             bus_reset_q, bus_reset_d;
  logic             suspend_q, suspend_d;
  logic             resume_q, resume_d;

  // On the first cycle of a new line state the stale count from the previous
  // run must not be compared, so the effective run length is forced to zero.
  always_comb begin
    w_run       = (w_line_state != prev_q) ? '0 : cnt_q;
    cnt_d       = (w_run == c_cnt_max) ? w_run : w_run + 1'b1;
    state_d     = state_q;
    resume_d    = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (w_line_state == LS_SE0 && w_run == c_reset_last) begin
          state_d = ST_BUS_RESET;
        end else if (w_line_state == LS_J && w_run == c_suspend_last) begin
          state_d = ST_SUSPEND;
        end
      end
      ST_BUS_RESET: begin
        if (w_line_state != LS_SE0) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_SUSPEND: begin
        if (w_line_state == LS_SE0 && w_run == c_reset_last) begin
          state_d = ST_BUS_RESET;
        end else if (w_line_state == LS_K && w_run == c_resume_last) begin
          state_d  = ST_ACTIVE;
          resume_d = 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
    bus_reset_d = (state_d == ST_BUS_RESET);
    suspend_d   = (state_d == ST_SUSPEND);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q      <= LS_J;
      cnt_q       <= '0;
      state_q     <= ST_ACTIVE;
      bus_reset_q <= 1'b0;
      suspend_q   <= 1'b0;
      resume_q    <= 1'b0;
    end else begin
      prev_q      <= w_line_state;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      bus_reset_q <= bus_reset_d;
      suspend_q   <= suspend_d;
      resume_q    <= resume_d;
    end
  end

  assign bus.line_state = w_line_state;
  assign bus.bus_reset  = bus_reset_q;
  assign bus.suspend    = suspend_q;
  assign bus.resume     = resume_q;

`ifdef USB_SE1_DETECT_EN
  logic se1_err_q, se1_err_d;

  // Looks one stage ahead so the pulse lines up with line_state showing SE1.
  always_comb begin
    se1_err_d = (w_stage1 == LS_SE1) && (w_line_state != LS_SE1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      se1_err_q <= 1'b0;
    end else begin
      se1_err_q <= se1_err_d;
    end
  end

  assign bus.se1_err = se1_err_q;
`else
  logic unused_stage1;
  assign unused_stage1 = ^{w_stage1};
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_bus_state.sv
// ============================================================================
// Module      : tb_usb_bus_state
// Description : Scoreboard bench for usb_bus_state with a time-stamp based
//               reference model; se1_err is checked when USB_SE1_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_bus_state;

  localparam int R  = 6;
  localparam int S  = 40;
  localparam int RS = 12;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  localparam int M_ACT = 0;
  localparam int M_RST = 1;
  localparam int M_SUS = 2;

  typedef logic [5:0] obs_t;  // {line_state, bus_reset, suspend, resume, se1_err}

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  usb_bus_state_if bus ();

  usb_bus_state #(
    .RESET_CYCLES   (R),
    .SUSPEND_CYCLES (S),
    .RESUME_CYCLES  (RS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  obs_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: edge index n, and the edge at which the visible line
  // value last changed; the held length follows from the difference.
  int         n;
  int         since;
  int         st;
  logic [1:0] p1;
  logic [1:0] ls;
  logic [1:0] cur_pins;
  logic       m_resume;
`ifdef USB_SE1_DETECT_EN
  logic       m_se1;
`endif

  function automatic obs_t observe();
    logic se1;
`ifdef USB_SE1_DETECT_EN
    se1 = bus.se1_err;
`else
    se1 = 1'b0;
`endif
    return {2'(bus.line_state), bus.bus_reset, bus.suspend, bus.resume, se1};
  endfunction

  task automatic model_reset();
    n        = 0;
    since    = 0;
    st       = M_ACT;
    p1       = J;
    ls       = J;
    m_resume = 1'b0;
`ifdef USB_SE1_DETECT_EN
    m_se1    = 1'b0;
`endif
  endtask

  task automatic model_step(input logic [1:0] pin, output obs_t e);
    int held;
    n        = n + 1;
    held     = n - 1 - since;
    m_resume = 1'b0;
    if (st == M_ACT) begin
      if (ls == SE0 && held == R - 1)     st = M_RST;
      else if (ls == J && held == S - 1)  st = M_SUS;
    end else if (st == M_RST) begin
      if (ls != SE0) st = M_ACT;
    end else begin
      if (ls == SE0 && held == R - 1) begin
        st = M_RST;
      end else if (ls == K && held == RS - 1) begin
        st       = M_ACT;
        m_resume = 1'b1;
      end
    end
`ifdef USB_SE1_DETECT_EN
    m_se1 = (p1 == SE1) && (ls != SE1);
`endif
    if (p1 != ls) since = n;
    ls = p1;
    p1 = pin;
`ifdef USB_SE1_DETECT_EN
    e = {ls, st == M_RST, st == M_SUS, m_resume, m_se1};
`else
    e = {ls, st == M_RST, st == M_SUS, m_resume, 1'b0};
`endif
  endtask

  task automatic drive(input logic [1:0] sym, input int len);
    obs_t e;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      cur_pins = sym;
      bus.dp   = sym[1];
      bus.dm   = sym[0];
      model_step(sym, e);
      exp_q.push_back(e);
    end
  endtask

  task automatic release_reset();
    obs_t e;
    @(negedge clk);
    reset_n = 1'b1;
    model_step(cur_pins, e);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string name);
    obs_t got;
    got      = observe();
    compared = compared + 1;
    if (got !== {J, 4'b0000}) begin
      mismatched = mismatched + 1;
      $display("FAIL %s at %0t: got {ls,br,sus,res,se1}=%b required %b",
               name, $time, got, {J, 4'b0000});
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh output vector.
  initial begin
    obs_t e;
    obs_t got;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        got      = observe();
        compared = compared + 1;
        if (got !== e) begin
          mismatched = mismatched + 1;
          $display("FAIL outputs at %0t: got {ls,br,sus,res,se1}=%b required %b",
                   $time, got, e);
        end
      end
    end
  end

  initial begin
    int sel;
    int len;
    logic [1:0] sym;

    cur_pins = J;
    bus.dp   = 1'b1;
    bus.dm   = 1'b0;
    model_reset();
    #12;
    check_reset_state("reset_state");
    release_reset();

    // Directed: reset threshold boundary.
    drive(J, 3);
    drive(SE0, R - 1);
    drive(J, 5);
    drive(SE0, R);
    drive(J, 5);
    drive(SE0, R + 4);
    // Suspend, short K glitch, then real resume and re-suspend.
    drive(J, S + 3);
    drive(K, RS - 1);
    drive(J, 4);
    drive(K, RS);
    drive(J, S + 2);
    // Bus reset straight out of suspend, then an idle run one short.
    drive(SE0, R + 2);
    drive(J, S - 1);
    drive(K, 3);
    drive(SE1, 5);
    drive(J, 3);

    // Asynchronous reset while bus_reset is high, with SE0 still on the pins.
    drive(SE0, R + 3);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    model_reset();
    repeat (3) @(negedge clk);
    release_reset();
    drive(SE0, R + 3);
    drive(J, 4);

    // Randomized segments biased toward the threshold lengths.
    for (int seg = 0; seg < 160; seg++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      sym = J;
      else if (sel < 6) sym = K;
      else if (sel < 9) sym = SE0;
      else              sym = SE1;
      case ($urandom_range(0, 5))
        0:       len = int'($urandom_range(1, 4));
        1:       len = R - 1 + int'($urandom_range(0, 1));
        2:       len = RS - 1 + int'($urandom_range(0, 1));
        3:       len = S - 1 + int'($urandom_range(0, 2));
        default: len = int'($urandom_range(1, S + 5));
      endcase
      if (seg % 10 == 0) begin
        drive(J, S + 1);
      end
      drive(sym, len);
    end

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_bus_state.md
# usb_bus_state

Full-speed USB bus-state monitor for the device side, clocked by the 24 MHz system clock. It samples the raw D+/D− pins, synchronizes them, and classifies the line state. It detects the three host-driven bus conditions: bus reset (long SE0), suspend (long idle J) and resume (long K while suspended). Its `bus_reset` output drives the device core's soft reset, alongside the push-button reset path.

## Interface
- `RESET_CYCLES`, 60: consecutive SE0 cycles that qualify as bus reset (2.5 µs at 24 MHz).
- `SUSPEND_CYCLES`, 72000: consecutive J cycles that qualify as suspend (3 ms).
- `RESUME_CYCLES`, 480: consecutive K cycles in suspend that qualify as resume (20 µs).
- Constraint: all values ≥ 2; `RESET_CYCLES` < `SUSPEND_CYCLES`.
- `clk` in 1: system clock (24 MHz).
- `reset_n` in 1: asynchronous, active-low reset.
- `dp` in 1: raw D+ pin, asynchronous.
- `dm` in 1: raw D− pin, asynchronous.
- `line_state` out 2: synchronized {dp,dm}.
- `bus_reset` out 1: high while bus reset is in effect.
- `suspend` out 1: high while the bus is suspended.
- `resume` out 1: one-cycle pulse on resume detection.
- `se1_err` out 1: SE1 seen; present only with `USB_SE1_DETECT_EN`.

## Operation
- Line encoding {dp,dm}: J=2'b10, K=2'b01, SE0=2'b00, SE1=2'b11.
- Synchronization: two flops per pin. Synchronizer reset value is J, so reset never produces a spurious SE0.
- Run counter `cnt`:
  - Counts consecutive cycles of unchanged `line_state`.
  - Loads 1 on the first cycle of a new state, otherwise increments.
  - Saturates at `SUSPEND_CYCLES`.
  - Width $clog2(SUSPEND_CYCLES+1).
- FSM states: ACTIVE, BUS_RESET, SUSPEND.
  - ACTIVE → BUS_RESET: `line_state`=SE0 and `cnt`=RESET_CYCLES−1.
  - ACTIVE → SUSPEND: `line_state`=J and `cnt`=SUSPEND_CYCLES−1.
  - BUS_RESET → ACTIVE: `line_state`≠SE0. Next idle measurement starts from 0.
  - SUSPEND → ACTIVE with `resume` pulse: `line_state`=K and `cnt`=RESUME_CYCLES−1.
  - SUSPEND → BUS_RESET: SE0 qualifies as in ACTIVE. No `resume` pulse.
- Short K/SE0 glitches in SUSPEND only restart the counter; the state stays SUSPEND.
- Outputs are registered and decoded from the next state: `bus_reset`=(BUS_RESET), `suspend`=(SUSPEND).
- Reset values:
  - All outputs 0, except `line_state`=2'b10.
  - FSM in ACTIVE, `cnt`=0.
- Reset asserted mid-operation clears everything immediately and asynchronously. Measurements restart after release.

## Timing
- Pin-to-`line_state` latency: 2 edges.
- Count edges from E0, the first rising edge that samples a new value on the pins.
- `bus_reset` rises at edge E0+RESET_CYCLES+1 if SE0 is held. It falls at edge E0+2 after the pins return to non-SE0.
- `suspend` rises at E0+SUSPEND_CYCLES+1 for continuous J.
- `resume` is high for exactly the one cycle after E0+RESUME_CYCLES+1 edges of K. `suspend` falls on that same edge.
- Shorter runs produce no output change. SE0 lasting RESET_CYCLES−1 cycles is ignored.

## Configuration
- `USB_SE1_DETECT_EN`:
  - Defined: `se1_err` exists. It is registered and pulses high one cycle when `line_state` enters SE1.
  - Defined or not: SE1 resets the run counter like any other state change. It never causes a state transition.
  - Not defined: port and logic are absent.

## Structure
- Package `usb_pkg` holds:
  - `line_state_t` enum (J, K, SE0, SE1 encodings above).
  - `bus_state_t` enum (ACTIVE, BUS_RESET, SUSPEND).
- Sub-module `usb_line_sync`: two-flop synchronizer for {dp,dm}, asynchronously reset to J. Reusable by the receiver.

## Test plan
- SE0 for 59 cycles then J → `bus_reset` stays 0. SE0 for 60 cycles → `bus_reset` high at E0+61, low 2 edges after J returns.
- J for 72000 cycles → `suspend` high at E0+72001. J for 71999 cycles then K → `suspend` stays 0.
- In SUSPEND, K for 479 cycles then J → no change. K for 480 cycles → `resume` one-cycle pulse and `suspend` falls on the same edge.
- In SUSPEND, SE0 for 60 cycles → `suspend` falls, `bus_reset` rises, `resume` stays 0.
- `reset_n` low while `bus_reset`=1 → all outputs 0 and `line_state`=2'b10 asynchronously. After release, fresh SE0 needs 60 cycles again.
- With `USB_SE1_DETECT_EN`: 5 cycles of SE1 → `se1_err` single pulse 2 edges after pins, no FSM change. Without the macro, the bench compiles with no `se1_err` port.
